// File: rtl/vector_sum_pkg.sv
// Shared types and default sizes for the element-wise vector adder.
package vector_sum_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefAddrWidth  = 10;
  localparam int unsigned DefVectorSize = 64;

endpackage

// File: rtl/vector_sum_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage is never reset; only the read register is.
module sdp_bram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  wr_ok, rd_ok;

  // Out-of-range addresses must not alias onto low entries.
  assign wr_ok = we_i && (32'(waddr_i) < DEPTH);
  assign rd_ok = 32'(raddr_i) < DEPTH;

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_ok) begin
      rdata_d = mem_q[raddr_i[IdxW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_sum_top.sv
// Element-wise vector adder z[i] = x[i] + y[i] over three on-chip buffers,
// driven by a host load / start / done / readback protocol.
module vector_sum_top
  import vector_sum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned VECTOR_SIZE = DefVectorSize
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] x_wr_addr,
  input  logic                  x_wr_en,
  input  logic [DATA_WIDTH-1:0] x_din,
  input  logic [ADDR_WIDTH-1:0] y_wr_addr,
  input  logic                  y_wr_en,
  input  logic [DATA_WIDTH-1:0] y_din,
  input  logic [ADDR_WIDTH-1:0] z_rd_addr,
  output logic [DATA_WIDTH-1:0] z_dout
);

  if (VECTOR_SIZE > (2 ** ADDR_WIDTH)) begin : g_size_check
    $error("VECTOR_SIZE does not fit in ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(VECTOR_SIZE - 1);

  state_e                state_d, state_q;
  logic [ADDR_WIDTH-1:0] rd_idx_d, rd_idx_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic                  wr_vld_d, wr_vld_q;
  logic                  done_d, done_q;

  logic                  host_ok;
  logic [DATA_WIDTH-1:0] x_rdata, y_rdata, sum;

  assign host_ok = (state_q == StIdle) || (state_q == StDone);
  assign sum     = x_rdata + y_rdata;

  sdp_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (VECTOR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_x_buf (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (x_wr_en && host_ok),
    .waddr_i(x_wr_addr),
    .wdata_i(x_din),
    .raddr_i(rd_idx_q),
    .rdata_o(x_rdata)
  );

  sdp_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (VECTOR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_y_buf (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (y_wr_en && host_ok),
    .waddr_i(y_wr_addr),
    .wdata_i(y_din),
    .raddr_i(rd_idx_q),
    .rdata_o(y_rdata)
  );

  sdp_bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (VECTOR_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_z_buf (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (wr_vld_q),
    .waddr_i(wr_addr_q),
    .wdata_i(sum),
    .raddr_i(z_rd_addr),
    .rdata_o(z_dout)
  );

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    wr_addr_d = wr_addr_q;
    wr_vld_d  = 1'b0;
    done_d    = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          rd_idx_d = '0;
          done_d   = 1'b0;
        end
      end
      StRun: begin
        // Read data for rd_idx_q arrives next cycle; the delay line tags it.
        rd_idx_d  = rd_idx_q + 1'b1;
        wr_vld_d  = 1'b1;
        wr_addr_d = rd_idx_q;
        if (rd_idx_q == LastIdx) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!wr_vld_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      wr_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      wr_addr_q <= wr_addr_d;
      wr_vld_q  <= wr_vld_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_vector_sum_top.sv
// Scoreboard bench for vector_sum_top: directed loads and runs, with z readback
// checked by a monitor that pops expected values one cycle after each read.
module tb_vector_sum_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [9:0]  x_wr_addr = '0;
  logic        x_wr_en   = 1'b0;
  logic [31:0] x_din     = '0;
  logic [9:0]  y_wr_addr = '0;
  logic        y_wr_en   = 1'b0;
  logic [31:0] y_din     = '0;
  logic [9:0]  z_rd_addr = '0;
  logic [31:0] z_dout;

  logic        rd_vld = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  vector_sum_top #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .VECTOR_SIZE(64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .x_wr_addr(x_wr_addr),
    .x_wr_en  (x_wr_en),
    .x_din    (x_din),
    .y_wr_addr(y_wr_addr),
    .y_wr_en  (y_wr_en),
    .y_din    (y_din),
    .z_rd_addr(z_rd_addr),
    .z_dout   (z_dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read issued before edge P is compared just after P.
  initial begin
    logic v;
    forever begin
      @(posedge clock);
      v = rd_vld;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check(name_q.pop_front(), z_dout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input bit wx, input bit wy, input int addr,
                    input logic [31:0] xv, input logic [31:0] yv);
    @(negedge clock);
    x_wr_en   = wx;
    y_wr_en   = wy;
    x_wr_addr = 10'(addr);
    y_wr_addr = 10'(addr);
    x_din     = xv;
    y_din     = yv;
  endtask

  task automatic wr_idle();
    @(negedge clock);
    x_wr_en = 1'b0;
    y_wr_en = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [31:0] exp, input string name);
    @(negedge clock);
    z_rd_addr = 10'(addr);
    rd_vld    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back($sformatf("%s[%0d]", name, addr));
  endtask

  task automatic rd_idle();
    @(negedge clock);
    rd_vld = 1'b0;
  endtask

  // Pulses start, optionally injects a write to x[3] plus a start during RUN,
  // and counts edges after the start edge until done is seen.
  task automatic do_run(input int inject_at, input string name);
    int edges;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check({name, "_done_drop"}, 32'(done), 32'd0);
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (edges == inject_at) begin
        start     = 1'b1;
        x_wr_en   = 1'b1;
        x_wr_addr = 10'd3;
        x_din     = 32'h0000_DEAD;
      end
      @(posedge clock);
      #1;
      start   = 1'b0;
      x_wr_en = 1'b0;
      edges++;
    end
    check({name, "_latency"}, 32'(edges), 32'd66);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_done", 32'(done), 32'd0);
    check("rst_z_dout", z_dout, 32'd0);
    reset = 1'b1;

    // Basic: x[i]=i, y[i]=100+i -> z[i]=100+2i.
    for (int i = 0; i < 64; i++) wr(1'b1, 1'b1, i, 32'(i), 32'(100 + i));
    wr_idle();
    do_run(-1, "basic");
    for (int i = 0; i < 64; i++) rd(i, 32'(100 + 2 * i), "basic_z");
    // Readback latency on consecutive cycles, then out-of-range reads.
    rd(5, 32'd110, "lat_z");
    rd(7, 32'd114, "lat_z");
    rd(64, 32'd0, "oor_z");
    rd(1023, 32'd0, "oor_z");
    rd_idle();

    // Wrap: FFFFFFFF + 2 = 1; out-of-range writes must not alias onto entry 0.
    for (int i = 0; i < 64; i++) wr(1'b1, 1'b1, i, 32'hFFFF_FFFF, 32'd2);
    wr(1'b1, 1'b1, 64, 32'h0000_0555, 32'h0000_0777);
    wr(1'b1, 1'b1, 1024 - 64, 32'h0000_0123, 32'h0000_0456);
    wr_idle();
    do_run(-1, "wrap");
    for (int i = 0; i < 64; i += 7) rd(i, 32'd1, "wrap_z");
    rd(63, 32'd1, "wrap_z");
    rd_idle();

    // Reset mid-run: x[i]=3i, y[i]=1000; abort 20 edges after the start edge.
    for (int i = 0; i < 64; i++) wr(1'b1, 1'b1, i, 32'(3 * i), 32'd1000);
    wr_idle();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_z_dout", z_dout, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_done_idle", 32'(done), 32'd0);
    // Issues 0..19 happened, writes 0..18 landed; the rest keep wrap results.
    rd(0, 32'd1000, "partial_z");
    rd(18, 32'd1054, "partial_z");
    rd(19, 32'd1, "partial_z");
    rd(63, 32'd1, "partial_z");
    rd_idle();
    do_run(-1, "rerun");
    for (int i = 0; i < 64; i += 5) rd(i, 32'(3 * i + 1000), "rerun_z");
    rd(63, 32'd1189, "rerun_z");
    rd_idle();

    // Ignored traffic: x[3]=DEAD and a start pulse during RUN.
    do_run(5, "ignored");
    rd(3, 32'd1009, "ignored_z");
    rd(2, 32'd1006, "ignored_z");
    rd_idle();

    // Back-to-back from DONE with a new y; x[3] must still be 9.
    for (int i = 0; i < 64; i++) wr(1'b0, 1'b1, i, 32'd0, 32'd5);
    wr_idle();
    check("b2b_done_held", 32'(done), 32'd1);
    do_run(-1, "b2b");
    rd(3, 32'd14, "b2b_z");
    rd(0, 32'd5, "b2b_z");
    rd(63, 32'd194, "b2b_z");
    rd_idle();

    repeat (4) @(negedge clock);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_sum_top.md
Name: vector_sum_top

Overview:
Element-wise vector adder, z[i] = x[i] + y[i] for i in 0..VECTOR_SIZE-1, with three on-chip buffers (x, y, z).
The host loads x and y through write ports, pulses start, waits for done, then reads z through a synchronous read port.
The matrix-multiply flow uses it with VECTOR_SIZE = N*N (default 8*8 = 64) as a flat elementwise stage.

Parameters:
DATA_WIDTH, 32, element width in bits for x, y and z
ADDR_WIDTH, 10, width of every address port; VECTOR_SIZE must be <= 2**ADDR_WIDTH (elaboration-time assertion)
VECTOR_SIZE, 64, number of elements processed per run; also the depth of each buffer

Ports:
clock  in  1  single system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle start pulse, sampled on rising clock
done   out  1  high when the result is complete; held until the next accepted start or reset
x_wr_addr  in  ADDR_WIDTH  x buffer write address
x_wr_en    in  1  x buffer write enable
x_din      in  DATA_WIDTH  x buffer write data
y_wr_addr  in  ADDR_WIDTH  y buffer write address
y_wr_en    in  1  y buffer write enable
y_din      in  DATA_WIDTH  y buffer write data
z_rd_addr  in  ADDR_WIDTH  z buffer read address
z_dout     out DATA_WIDTH  z buffer read data, registered

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; done=0; internal counters=0; z_dout=0. Buffer contents are not cleared.
- Host writes: on a rising edge with x_wr_en=1, x[x_wr_addr] <= x_din (same for y). Accepted only in IDLE or DONE; ignored in RUN/DRAIN.
- Writes with address >= VECTOR_SIZE are ignored.
- z read: z_dout <= z[z_rd_addr] on every rising edge, giving 1-cycle latency. Out-of-range addresses return 0. Reads are allowed in any state; during RUN the data is unspecified.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start=1: go to RUN; rd_idx=0; done<=0.
- RUN: each cycle issue a synchronous read of x[rd_idx] and y[rd_idx], then rd_idx++. Data returns one cycle later and is written as z[rd_idx-1] = x+y. After issuing rd_idx=VECTOR_SIZE-1, go to DRAIN.
- DRAIN: perform the final z write, then go to DONE with done<=1.
- Latency: done rises exactly VECTOR_SIZE+2 rising edges after the edge that samples start (66 for the default).
- start while in RUN or DRAIN is ignored.
- Arithmetic: unsigned addition modulo 2**DATA_WIDTH; the carry is discarded; no overflow flag.
- Reset mid-run: abort immediately to IDLE with done=0. z is partially written; no further writes occur.
- A simultaneous host write and start in IDLE: the write lands first, at that same edge, and the run sees the new value.

Decomposition:
- Package vector_sum_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE) and default width constants.
- Sub-module sdp_bram (DATA_WIDTH, DEPTH, ADDR_WIDTH): one write port and one registered read port, no reset on the storage array.
- Instantiate sdp_bram three times (x, y, z).
- The top level holds the FSM, the index counter, the one-cycle valid/address delay line, and the adder.

Test Plan:
- Basic: x[i]=i, y[i]=100+i for i in 0..63; pulse start -> done after 66 cycles; z[i]=100+2i for all 64 entries; 0 errors.
- Wrap: x[i]=FFFFFFFF, y[i]=2 -> z[i]=00000001 for all i.
- Readback latency: after done, set z_rd_addr=5, then 7 on consecutive cycles -> z_dout shows z[5], then z[7], each one cycle later.
- Reset mid-run: assert reset 20 cycles after start -> done=0 immediately, FSM in IDLE. A new start gives correct full results 66 cycles later.
- Ignored traffic: write x[3]=DEAD during RUN and pulse start during RUN -> z[3] uses the old x[3], done timing is unchanged, and after done x[3] still holds the old value.
- Back-to-back runs: change y, pulse start while in DONE -> done drops next cycle, re-rises 66 cycles after start, z reflects the new y.
